// File: rtl/seg7_pair_decoder.sv
// seg7_pair_decoder: watches a two-digit active-low seven-segment bus,
// debounces the pattern pair, decodes it to 0..MAX_VALUE and classifies
// every accepted change as a +1 step, a wrap or an illegal jump.
module seg7_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_VALUE     = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] seg_ones,
    input  logic [6:0] seg_tens,
    input  logic       clr_err,
    output logic [5:0] value,
    output logic       value_valid,
    output logic       step_up,
    output logic       wrap,
    output logic       skip,
    output logic       pattern_err,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE_V8 = 8'(STABLE_CYCLES);
    localparam logic [6:0] MAX_V7    = 7'(MAX_VALUE);
    localparam logic [5:0] MAX_V6    = 6'(MAX_VALUE);
    localparam logic [6:0] BLANK     = 7'b111_1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    // Decode one active-low digit; bit 4 of the result flags a legal digit.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg);
        case (seg)
            7'b000_0001: return 5'b1_0000;
            7'b100_1111: return 5'b1_0001;
            7'b001_0010: return 5'b1_0010;
            7'b000_0110: return 5'b1_0011;
            7'b100_1100: return 5'b1_0100;
            7'b010_0100: return 5'b1_0101;
            7'b010_0000: return 5'b1_0110;
            7'b000_1111: return 5'b1_0111;
            7'b000_0000: return 5'b1_1000;
            7'b000_0100: return 5'b1_1001;
            default:     return 5'b0_0000;
        endcase
    endfunction

    logic [6:0] samp_ones_r;
    logic [6:0] samp_tens_r;
    logic [7:0] run_r;
    logic       acc_done_r;
    state_t     state_r;
    logic [5:0] value_r;
    logic       value_valid_r;
    logic       step_up_r;
    logic       wrap_r;
    logic       skip_r;
    logic       pattern_err_r;
    logic [7:0] err_count_r;

    logic [4:0] dec_ones_s;
    logic [4:0] dec_tens_s;
    logic [6:0] sum_s;
    logic       legal_s;
    logic       blank_s;
    logic       accept_s;
    logic       same_s;
    logic       illegal_acc_s;

    // Decode the held sample pair and decide whether this cycle accepts it.
    always_comb begin
        dec_ones_s    = decode_digit(samp_ones_r);
        dec_tens_s    = decode_digit(samp_tens_r);
        sum_s         = ({3'b000, dec_tens_s[3:0]} * 7'd10) + {3'b000, dec_ones_s[3:0]};
        blank_s       = (samp_ones_r == BLANK) || (samp_tens_r == BLANK);
        legal_s       = dec_ones_s[4] && dec_tens_s[4] &&
                        (dec_tens_s[3:0] <= 4'd5) && (sum_s <= MAX_V7);
        same_s        = (seg_ones == samp_ones_r) && (seg_tens == samp_tens_r);
        accept_s      = enable && (run_r == STABLE_V8) && !acc_done_r;
        if (accept_s && !blank_s && !legal_s) begin
            illegal_acc_s = 1'b1;
        end else begin
            illegal_acc_s = 1'b0;
        end
    end

    // Sample the bus and count how long the same pair has been seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_ones_r <= BLANK;
            samp_tens_r <= BLANK;
            run_r       <= 8'd0;
            acc_done_r  <= 1'b0;
        end else if (!enable) begin
            run_r      <= 8'd0;
            acc_done_r <= 1'b0;
        end else begin
            samp_ones_r <= seg_ones;
            samp_tens_r <= seg_tens;
            if (same_s) begin
                if (run_r != STABLE_V8) begin
                    run_r <= run_r + 8'd1;
                end else begin
                    run_r <= run_r;
                end
                if (accept_s) begin
                    acc_done_r <= 1'b1;
                end else begin
                    acc_done_r <= acc_done_r;
                end
            end else begin
                run_r      <= 8'd1;
                acc_done_r <= 1'b0;
            end
        end
    end

    // Error counter: cleared by clr_err, bumped by illegal acceptances, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_r <= 8'd0;
        end else if (clr_err) begin
            err_count_r <= illegal_acc_s ? 8'd1 : 8'd0;
        end else if (illegal_acc_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    // Acceptance FSM: update value, state, pattern_err and one-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            value_r       <= 6'd0;
            value_valid_r <= 1'b0;
            step_up_r     <= 1'b0;
            wrap_r        <= 1'b0;
            skip_r        <= 1'b0;
            pattern_err_r <= 1'b0;
        end else begin
            value_valid_r <= 1'b0;
            step_up_r     <= 1'b0;
            wrap_r        <= 1'b0;
            skip_r        <= 1'b0;
            if (accept_s && !blank_s) begin
                if (legal_s) begin
                    pattern_err_r <= 1'b0;
                    case (state_r)
                        IDLE: begin
                            value_r       <= sum_s[5:0];
                            value_valid_r <= 1'b1;
                        end
                        LOCKED, ERROR: begin
                            if (sum_s[5:0] != value_r) begin
                                value_r       <= sum_s[5:0];
                                value_valid_r <= 1'b1;
                                if ((value_r == MAX_V6) && (sum_s[5:0] == 6'd0)) begin
                                    wrap_r <= 1'b1;
                                end else if (sum_s[5:0] == value_r + 6'd1) begin
                                    step_up_r <= 1'b1;
                                end else begin
                                    skip_r <= 1'b1;
                                end
                            end else begin
                                value_r <= value_r;
                            end
                        end
                        default: begin
                            value_r <= value_r;
                        end
                    endcase
                    state_r <= LOCKED;
                end else begin
                    pattern_err_r <= 1'b1;
                    state_r       <= ERROR;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign value       = value_r;
    assign value_valid = value_valid_r;
    assign step_up     = step_up_r;
    assign wrap        = wrap_r;
    assign skip        = skip_r;
    assign pattern_err = pattern_err_r;
    assign err_count   = err_count_r;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// Scoreboard bench for seg7_pair_decoder: stimulus pushes the expected
// value/classification of each accepted change, a monitor pops on pulses.
module tb_seg7_pair_decoder;

    localparam int S = 4;

    localparam logic [6:0] D0 = 7'b000_0001;
    localparam logic [6:0] D2 = 7'b001_0010;
    localparam logic [6:0] D3 = 7'b000_0110;
    localparam logic [6:0] D4 = 7'b100_1100;
    localparam logic [6:0] D5 = 7'b010_0100;
    localparam logic [6:0] D7 = 7'b000_1111;
    localparam logic [6:0] D8 = 7'b000_0000;
    localparam logic [6:0] D9 = 7'b000_0100;
    localparam logic [6:0] BL = 7'b111_1111;
    localparam logic [6:0] JUNK = 7'b111_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;
    logic       clr_err;
    logic [5:0] value;
    logic       value_valid;
    logic       step_up;
    logic       wrap;
    logic       skip;
    logic       pattern_err;
    logic [7:0] err_count;

    typedef struct packed {
        logic [5:0] val;
        logic       s;
        logic       w;
        logic       k;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    seg7_pair_decoder #(.STABLE_CYCLES(S), .MAX_VALUE(59)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .seg_ones(seg_ones), .seg_tens(seg_tens), .clr_err(clr_err),
        .value(value), .value_valid(value_valid), .step_up(step_up),
        .wrap(wrap), .skip(skip), .pattern_err(pattern_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int v, input logic s, input logic w, input logic k);
        exp_t e;
        e.val = 6'(v);
        e.s = s;
        e.w = w;
        e.k = k;
        exp_q.push_back(e);
    endtask

    // Drive a pair at the current negedge and hold it for n cycles.
    task automatic hold(input logic [6:0] t, input logic [6:0] o, input int n);
        seg_tens = t;
        seg_ones = o;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse cycle must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && (value_valid || step_up || wrap || skip)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got value=%0d vv=%0b s=%0b w=%0b k=%0b expected none",
                         value, value_valid, step_up, wrap, skip);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_value", int'(value), int'(e.val));
                chk("pulse_vv", int'(value_valid), 1);
                chk("pulse_step", int'(step_up), int'(e.s));
                chk("pulse_wrap", int'(wrap), int'(e.w));
                chk("pulse_skip", int'(skip), int'(e.k));
            end
        end
    end

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        clr_err = 1'b0;
        seg_ones = BL;
        seg_tens = BL;
        repeat (3) @(negedge clk);
        chk("rst_value", int'(value), 0);
        chk("rst_vv", int'(value_valid), 0);
        chk("rst_perr", int'(pattern_err), 0);
        chk("rst_errcnt", int'(err_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // First acceptance from IDLE with exact latency.
        push(3, 1'b0, 1'b0, 1'b0);
        hold(D0, D3, S);
        chk("lat_early_vv", int'(value_valid), 0);
        @(negedge clk);
        chk("lat_vv", int'(value_valid), 1);
        chk("lat_value", int'(value), 3);
        repeat (6) @(negedge clk);

        // Walk 03 -> 04 -> 05.
        push(4, 1'b1, 1'b0, 1'b0);
        hold(D0, D4, 8);
        push(5, 1'b1, 1'b0, 1'b0);
        hold(D0, D5, 8);
        chk("walk_value", int'(value), 5);

        // 05 -> 59 is a jump, 59 -> 00 is a wrap.
        push(59, 1'b0, 1'b0, 1'b1);
        hold(D5, D9, 8);
        push(0, 1'b0, 1'b1, 1'b0);
        hold(D0, D0, 8);
        chk("wrap_value", int'(value), 0);

        // Short glitch is ignored, then a jump to 42.
        hold(D0, D5, 2);
        hold(D0, D0, 8);
        chk("glitch_value", int'(value), 0);
        chk("glitch_perr", int'(pattern_err), 0);
        chk("glitch_errcnt", int'(err_count), 0);
        push(42, 1'b0, 1'b0, 1'b1);
        hold(D4, D2, 8);

        // Illegal pair "80" holds value, flags error once.
        hold(D8, D0, 12);
        chk("ill_perr", int'(pattern_err), 1);
        chk("ill_errcnt", int'(err_count), 1);
        chk("ill_value", int'(value), 42);
        push(43, 1'b1, 1'b0, 1'b0);
        hold(D4, D3, 8);
        chk("rec_perr", int'(pattern_err), 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_errcnt", int'(err_count), 0);

        // Alternate two illegal pairs to saturate the counter.
        for (int i = 0; i < 130; i++) begin
            hold(D8, D0, 6);
            hold(D0, JUNK, 6);
        end
        chk("sat_errcnt", int'(err_count), 255);
        chk("sat_perr", int'(pattern_err), 1);
        chk("sat_value", int'(value), 43);

        // Reset in the middle of a run (run counter at 3).
        hold(D0, D7, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_value", int'(value), 0);
        chk("mid_rst_perr", int'(pattern_err), 0);
        chk("mid_rst_errcnt", int'(err_count), 0);
        chk("mid_rst_vv", int'(value_valid), 0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Disabled: constant pair produces nothing.
        hold(D0, D7, 10);
        chk("dis_value", int'(value), 0);
        push(7, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (S) @(negedge clk);
        chk("en_early_vv", int'(value_valid), 0);
        @(negedge clk);
        chk("en_vv", int'(value_valid), 1);
        chk("en_value", int'(value), 7);
        repeat (6) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
